// File: rtl/core_param.sv
// Shared register-file parameters and types for the integer core.
package core_param;

  typedef logic [4:0]  RegAddrBus;
  typedef logic [31:0] RegBus;

  localparam int unsigned RegNum        = 32;
  localparam RegAddrBus   ZeroReg       = 5'd0;
  localparam RegBus       ZeroWord      = 32'h0;
  localparam logic        REGWEN_ENABLE = 1'b1;
  localparam int unsigned LdDepth       = 2;

  function automatic logic is_zero_reg(input RegAddrBus rd);
    return rd == ZeroReg;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding {rd, data} load responses awaiting write-back.
module wb_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 37
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/reg_wb_unit.sv
// Register-file write-back: merges ALU results and buffered load responses, and tracks
// busy load destinations for hazard detection. LD_BYPASS_EN enables the empty-FIFO bypass.
module reg_wb_unit
  import core_param::*;
#(
  parameter int unsigned LD_DEPTH = LdDepth,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            alu_valid_i,
  input  logic [4:0]      alu_rd_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic            ld_issue_i,
  input  logic [4:0]      ld_rd_i,
  output logic            ld_issue_ready_o,
  input  logic            ld_rsp_valid_i,
  output logic            ld_rsp_ready_o,
  input  logic [4:0]      ld_rsp_rd_i,
  input  logic [XLEN-1:0] ld_rsp_data_i,
  input  logic [4:0]      chk_rs1_i,
  input  logic [4:0]      chk_rs2_i,
  input  logic [4:0]      chk_rd_i,
  output logic            hazard_o,
  output logic            RegWEn_o,
  output logic [4:0]      AddrD_o,
  output logic [XLEN-1:0] DataD_o
);

  localparam int unsigned CntW   = $clog2(LD_DEPTH + 1);
  localparam int unsigned EntryW = 5 + XLEN;

  logic [RegNum-1:0] busy_q, busy_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              wen_q, wen_d;
  logic [4:0]        addr_q, addr_d;
  logic [XLEN-1:0]   data_q, data_d;

  logic              fifo_full, fifo_empty;
  logic [EntryW-1:0] head;
  logic [4:0]        head_rd;
  logic [XLEN-1:0]   head_data;
  logic              pop, push, rsp_acc, bypass, issue, complete;
  logic [4:0]        comp_rd;

  assign head_rd   = head[EntryW-1:XLEN];
  assign head_data = head[XLEN-1:0];

  wb_fifo #(
    .Depth (LD_DEPTH),
    .Width (EntryW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i ({ld_rsp_rd_i, ld_rsp_data_i}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign ld_rsp_ready_o   = !fifo_full;
  assign ld_issue_ready_o = (32'(cnt_q) < LD_DEPTH) && !busy_q[ld_rd_i];
  assign hazard_o         = busy_q[chk_rs1_i] | busy_q[chk_rs2_i] | busy_q[chk_rd_i];

  assign rsp_acc = ld_rsp_valid_i && !fifo_full;
  assign pop     = !alu_valid_i && !fifo_empty;
`ifdef LD_BYPASS_EN
  assign bypass  = rsp_acc && !alu_valid_i && fifo_empty;
`else
  assign bypass  = 1'b0;
`endif
  assign push     = rsp_acc && !bypass;
  assign issue    = ld_issue_i && ld_issue_ready_o;
  assign complete = pop || bypass;
  assign comp_rd  = pop ? head_rd : ld_rsp_rd_i;

  always_comb begin
    wen_d  = ~REGWEN_ENABLE;
    addr_d = addr_q;
    data_d = data_q;
    if (alu_valid_i) begin
      wen_d  = is_zero_reg(alu_rd_i) ? ~REGWEN_ENABLE : REGWEN_ENABLE;
      addr_d = alu_rd_i;
      data_d = alu_data_i;
    end else if (pop) begin
      wen_d  = is_zero_reg(head_rd) ? ~REGWEN_ENABLE : REGWEN_ENABLE;
      addr_d = head_rd;
      data_d = head_data;
    end else if (bypass) begin
      wen_d  = is_zero_reg(ld_rsp_rd_i) ? ~REGWEN_ENABLE : REGWEN_ENABLE;
      addr_d = ld_rsp_rd_i;
      data_d = ld_rsp_data_i;
    end
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q + CntW'(issue) - CntW'(complete);
    if (complete) busy_d[comp_rd] = 1'b0;
    // x0 never becomes busy, so loads to x0 only consume a count slot.
    if (issue && !is_zero_reg(ld_rd_i)) busy_d[ld_rd_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
      wen_q  <= ~REGWEN_ENABLE;
      addr_q <= ZeroReg;
      data_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      wen_q  <= wen_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign RegWEn_o = wen_q;
  assign AddrD_o  = addr_q;
  assign DataD_o  = data_q;

  a_issue_ready: assert property (@(posedge clk_i) disable iff (!rst_i)
    ld_issue_i |-> ld_issue_ready_o);
  a_rsp_busy: assert property (@(posedge clk_i) disable iff (!rst_i)
    (rsp_acc && !is_zero_reg(ld_rsp_rd_i)) |-> busy_q[ld_rsp_rd_i]);

endmodule

// File: tb/tb_reg_wb_unit.sv
// Directed bench for reg_wb_unit with a write-back scoreboard.
module tb_reg_wb_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        ld_issue_i;
  logic [4:0]  ld_rd_i;
  logic        ld_issue_ready_o;
  logic        ld_rsp_valid_i;
  logic        ld_rsp_ready_o;
  logic [4:0]  ld_rsp_rd_i;
  logic [31:0] ld_rsp_data_i;
  logic [4:0]  chk_rs1_i, chk_rs2_i, chk_rd_i;
  logic        hazard_o;
  logic        RegWEn_o;
  logic [4:0]  AddrD_o;
  logic [31:0] DataD_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [36:0] sb [$];

  always #5 clk_i = ~clk_i;

  reg_wb_unit #(
    .LD_DEPTH (2),
    .XLEN     (32)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .alu_valid_i      (alu_valid_i),
    .alu_rd_i         (alu_rd_i),
    .alu_data_i       (alu_data_i),
    .ld_issue_i       (ld_issue_i),
    .ld_rd_i          (ld_rd_i),
    .ld_issue_ready_o (ld_issue_ready_o),
    .ld_rsp_valid_i   (ld_rsp_valid_i),
    .ld_rsp_ready_o   (ld_rsp_ready_o),
    .ld_rsp_rd_i      (ld_rsp_rd_i),
    .ld_rsp_data_i    (ld_rsp_data_i),
    .chk_rs1_i        (chk_rs1_i),
    .chk_rs2_i        (chk_rs2_i),
    .chk_rd_i         (chk_rd_i),
    .hazard_o         (hazard_o),
    .RegWEn_o         (RegWEn_o),
    .AddrD_o          (AddrD_o),
    .DataD_o          (DataD_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock, then compare any write-back against the scoreboard head.
  task automatic tick();
    logic [36:0] e;
    @(posedge clk_i);
    #1;
    if (RegWEn_o === 1'b1) begin
      chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wb_addr", 64'(AddrD_o), 64'(e[36:32]));
        chk("wb_data", 64'(DataD_o), 64'(e[31:0]));
      end
    end
  endtask

  initial begin
    rst_i = 1'b0;
    alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
    ld_issue_i = 0; ld_rd_i = 0;
    ld_rsp_valid_i = 0; ld_rsp_rd_i = 0; ld_rsp_data_i = 0;
    chk_rs1_i = 0; chk_rs2_i = 0; chk_rd_i = 0;
    #23;
    chk("rst_wen", 64'(RegWEn_o), 64'd0);
    chk("rst_addr", 64'(AddrD_o), 64'd0);
    chk("rst_data", 64'(DataD_o), 64'd0);
    chk("rst_issue_rdy", 64'(ld_issue_ready_o), 64'd1);
    chk("rst_rsp_rdy", 64'(ld_rsp_ready_o), 64'd1);
    chk("rst_hazard", 64'(hazard_o), 64'd0);
    rst_i = 1'b1;
    tick();
    tick();
    chk("idle_wen", 64'(RegWEn_o), 64'd0);

    // ALU write, then ALU write to x0
    alu_valid_i = 1; alu_rd_i = 5; alu_data_i = 32'h1234;
    sb.push_back({5'd5, 32'h1234});
    tick();
    chk("alu_wen", 64'(RegWEn_o), 64'd1);
    alu_rd_i = 0; alu_data_i = 32'h55;
    tick();
    chk("alu_x0_wen", 64'(RegWEn_o), 64'd0);
    alu_valid_i = 0;

    // Single load to x7
    ld_rd_i = 7; chk_rs1_i = 7;
    #1;
    chk("ld7_ready", 64'(ld_issue_ready_o), 64'd1);
    ld_issue_i = 1;
    tick();
    ld_issue_i = 0;
    chk("ld7_hazard", 64'(hazard_o), 64'd1);
    ld_rsp_valid_i = 1; ld_rsp_rd_i = 7; ld_rsp_data_i = 32'hDEADBEEF;
    sb.push_back({5'd7, 32'hDEADBEEF});
    tick();
    ld_rsp_valid_i = 0;
`ifndef LD_BYPASS_EN
    chk("ld7_not_yet", 64'(RegWEn_o), 64'd0);
    chk("ld7_hazard_held", 64'(hazard_o), 64'd1);
    tick();
`endif
    chk("ld7_wen", 64'(RegWEn_o), 64'd1);
    chk("ld7_hazard_clr", 64'(hazard_o), 64'd0);

    // Two loads outstanding, responses during ALU traffic
    ld_issue_i = 1; ld_rd_i = 3;
    tick();
    ld_rd_i = 4;
    tick();
    ld_issue_i = 0; ld_rd_i = 5;
    #1;
    chk("two_out_ready", 64'(ld_issue_ready_o), 64'd0);
    sb.push_back({5'd10, 32'hA0});
    sb.push_back({5'd11, 32'hA1});
    sb.push_back({5'd12, 32'hA2});
    sb.push_back({5'd3, 32'h3333});
    sb.push_back({5'd4, 32'h4444});
    alu_valid_i = 1; alu_rd_i = 10; alu_data_i = 32'hA0;
    ld_rsp_valid_i = 1; ld_rsp_rd_i = 3; ld_rsp_data_i = 32'h3333;
    tick();
    alu_rd_i = 11; alu_data_i = 32'hA1;
    ld_rsp_rd_i = 4; ld_rsp_data_i = 32'h4444;
    tick();
    alu_rd_i = 12; alu_data_i = 32'hA2;
    ld_rsp_valid_i = 0;
    tick();
    chk("fifo_full_rdy", 64'(ld_rsp_ready_o), 64'd0);
    alu_valid_i = 0;
    tick();
    tick();
    chk("drain_ready", 64'(ld_issue_ready_o), 64'd1);
    chk("drain_rsp_rdy", 64'(ld_rsp_ready_o), 64'd1);
    chk_rs1_i = 3; chk_rs2_i = 4;
    #1;
    chk("drain_hazard", 64'(hazard_o), 64'd0);
    chk_rs2_i = 0;

    // Issue to busy rd refused; same-cycle issue and completion
    ld_issue_i = 1; ld_rd_i = 3;
    tick();
    ld_issue_i = 0;
    #1;
    chk("busy_rd_refused", 64'(ld_issue_ready_o), 64'd0);
    sb.push_back({5'd3, 32'hC3C3});
    ld_rsp_valid_i = 1; ld_rsp_rd_i = 3; ld_rsp_data_i = 32'hC3C3;
`ifndef LD_BYPASS_EN
    tick();
    ld_rsp_valid_i = 0;
`endif
    ld_issue_i = 1; ld_rd_i = 9;
    tick();
    ld_issue_i = 0; ld_rsp_valid_i = 0;
    chk_rs1_i = 9;
    #1;
    chk("busy9_set", 64'(hazard_o), 64'd1);
    chk_rs1_i = 3;
    #1;
    chk("busy3_clr", 64'(hazard_o), 64'd0);
    ld_rd_i = 10;
    #1;
    chk("count_one_ready", 64'(ld_issue_ready_o), 64'd1);
    ld_issue_i = 1;
    tick();
    ld_issue_i = 0; ld_rd_i = 11;
    #1;
    chk("count_two_ready", 64'(ld_issue_ready_o), 64'd0);

    // Fill FIFO under ALU traffic, then reset mid-operation
    sb.push_back({5'd20, 32'h20});
    sb.push_back({5'd21, 32'h21});
    alu_valid_i = 1; alu_rd_i = 20; alu_data_i = 32'h20;
    ld_rsp_valid_i = 1; ld_rsp_rd_i = 9; ld_rsp_data_i = 32'h99;
    tick();
    alu_rd_i = 21; alu_data_i = 32'h21;
    ld_rsp_rd_i = 10; ld_rsp_data_i = 32'h1010;
    tick();
    alu_valid_i = 0; ld_rsp_valid_i = 0;
    chk("pre_rst_full", 64'(ld_rsp_ready_o), 64'd0);
    rst_i = 1'b0;
    chk_rs1_i = 9; chk_rd_i = 10;
    #1;
    chk("mid_rst_wen", 64'(RegWEn_o), 64'd0);
    chk("mid_rst_addr", 64'(AddrD_o), 64'd0);
    chk("mid_rst_data", 64'(DataD_o), 64'd0);
    chk("mid_rst_hazard", 64'(hazard_o), 64'd0);
    chk("mid_rst_rsp_rdy", 64'(ld_rsp_ready_o), 64'd1);
    ld_rd_i = 9;
    #1;
    chk("mid_rst_issue_rdy", 64'(ld_issue_ready_o), 64'd1);
    tick();
    rst_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_no_wen", 64'(RegWEn_o), 64'd0);
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_wb_unit.md
Name: reg_wb_unit

Overview:
- Write-back initiator for the integer register file. Drives its single write port: write enable, destination address and write data.
- Merges two result sources: single-cycle ALU results, and out-of-order-latency load responses held in a small FIFO.
- Keeps a per-register busy scoreboard of outstanding load destinations so decode can stall on RAW/WAW hazards.

Parameters:
- LD_DEPTH, 2, maximum outstanding loads; also the depth of the load-response FIFO (power of two, ≥2).
- XLEN, 32, data width; equals the shared RegBus width.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  reset, asynchronous, active-low.
- alu_valid_i  in  1  ALU result valid this cycle; always accepted.
- alu_rd_i  in  5  ALU destination register.
- alu_data_i  in  XLEN  ALU result.
- ld_issue_i  in  1  load issued by execute; valid only when ld_issue_ready_o=1.
- ld_rd_i  in  5  destination of the issued load.
- ld_issue_ready_o  out  1  load may issue this cycle.
- ld_rsp_valid_i  in  1  load response valid.
- ld_rsp_ready_o  out  1  FIFO can accept the response.
- ld_rsp_rd_i  in  5  response destination.
- ld_rsp_data_i  in  XLEN  loaded data.
- chk_rs1_i  in  5  decode source 1.
- chk_rs2_i  in  5  decode source 2.
- chk_rd_i  in  5  decode destination.
- hazard_o  out  1  any checked register is busy.
- RegWEn_o  out  1  register-file write enable, REGWEN_ENABLE polarity.
- AddrD_o  out  5  register-file write address.
- DataD_o  out  XLEN  register-file write data.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - RegWEn_o=0, AddrD_o=0, DataD_o=0.
  - Busy vector cleared, outstanding count=0, FIFO empty.
  - Outputs settle combinationally from this state: ld_issue_ready_o=1, ld_rsp_ready_o=1, hazard_o=0.
  - Reset mid-operation discards all buffered responses and pending scoreboard bits.
- Output register (RegWEn_o/AddrD_o/DataD_o) loads every cycle from, in priority order:
  1. ALU, if alu_valid_i.
  2. FIFO head, if the FIFO is non-empty; the head is popped that cycle.
  3. Otherwise RegWEn_o=0; AddrD_o/DataD_o hold their previous values.
- x0 handling: a selected result with rd=0 gives RegWEn_o=0. A FIFO pop with rd=0 still counts as completion.
- Latency:
  - ALU result at cycle N → write at N+1.
  - Load response accepted at cycle N → head visible at N+1 → write at N+2 at the earliest.
- ld_rsp_ready_o = FIFO not full. A response is accepted when ld_rsp_valid_i && ld_rsp_ready_o.
- Simultaneous FIFO push and pop on a full FIFO: push is refused because ready is computed from the current state.
- Outstanding count:
  - +1 on ld_issue_i.
  - −1 when the output register loads a FIFO entry.
  - Both in the same cycle: the count is unchanged.
- ld_issue_ready_o = (count < LD_DEPTH) && !busy[ld_rd_i]. Issuing to a busy rd is refused, so there are no WAW loads.
- Busy vector:
  - ld_issue_i sets busy[ld_rd_i] (never bit 0).
  - A FIFO pop clears busy[popped rd].
  - Set and clear of different registers in the same cycle both apply.
  - Set and clear of the same register cannot occur, because ready excludes it.
- hazard_o = busy[chk_rs1_i] | busy[chk_rs2_i] | busy[chk_rd_i], combinational; x0 is never busy.
- Load starvation under continuous ALU traffic is acceptable: decode stalls on hazard_o, which bounds it.
- Protocol violations to be flagged by assertions:
  - ld_issue_i while ld_issue_ready_o=0.
  - A response for an rd that is not busy.

Optional Feature:
- LD_BYPASS_EN.
- Defined: when alu_valid_i=0 and the FIFO is empty, an accepted response loads the output register directly, bypassing the FIFO. Latency drops to 1 cycle, and busy/count update in that same cycle.
- Undefined: all responses pass through the FIFO (minimum latency 2).

Decomposition:
- Shared package core_param: RegAddrBus, RegBus, RegNum, ZeroReg, ZeroWord, REGWEN_ENABLE, plus a new LdDepth default.
- One natural sub-module: wb_fifo, a parameterised synchronous FIFO storing {rd, data}. It has push/pop/full/empty and uses the same asynchronous active-low reset.

Test Plan:
- Reset then idle → RegWEn_o=0, hazard_o=0, ld_issue_ready_o=1, ld_rsp_ready_o=1.
- alu_valid_i=1, rd=5, data=0x1234 at cycle N → RegWEn_o=1, AddrD_o=5, DataD_o=0x1234 at N+1; rd=0 → RegWEn_o stays 0.
- Load issue to rd=7 → hazard_o=1 for chk_rs1_i=7. Response 0xDEADBEEF, no ALU → write at N+2 (N+1 with LD_BYPASS_EN), then hazard_o=0.
- Two loads to rd 3 and 4 outstanding → ld_issue_ready_o=0. Responses arrive while alu_valid_i=1 for 3 cycles → ALU writes first, loads drain in order afterwards, ready returns.
- Issue to already-busy rd=3 → ld_issue_ready_o=0. Same-cycle issue to rd=9 and pop of rd=3 → busy[9]=1, busy[3]=0, count unchanged.
- rst_i asserted with a full FIFO and busy bits set → all outputs and state cleared immediately, with no spurious write after release.
